keypad_scan_ctrl: RTL and testbench

- Scan controller for the 4x4 matrix keypad.
- Drives one column low at a time and samples the four row lines. Row lines arrive already debounced and active-low, one debounce instance per row upstream.
- Encodes the first pressed key into a 4-bit code and offers it on a valid/ack handshake to the display/consumer logic.
- Waits for a stable release before scanning resumes, giving one report per keypress.

---
 rtl/keypad_scan_ctrl.sv | 118 +++++++++++
 tb/tb_keypad_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time,
// reports the first pressed key on a valid/ack handshake, then waits for release.
module keypad_scan_ctrl #(
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned RELEASE_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ack,
    output logic [1:0] scan_col
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        REPORT   = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] RELEASE_LAST = 16'(RELEASE_CYC - 1);

    state_t      state_q, state_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [3:0]  col_n_q, col_n_d;
    logic [15:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [3:0]  code_q, code_d;

    logic [1:0]  row_sel;
    logic        rows_idle;

    assign rows_idle = (row_n == 4'b1111);

    // Row 0 has the highest priority, so scan downwards and keep the last hit.
    always_comb begin
        row_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_n[i]) row_sel = 2'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        col_n_d   = col_n_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        code_d    = code_q;
        unique case (state_q)
            SCAN: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = 16'd0;
                    if (rows_idle) begin
                        col_idx_d = col_idx_q + 2'd1;
                        col_n_d   = ~(4'b0001 << col_idx_d);
                    end else begin
                        code_d  = {row_sel, col_idx_q};
                        valid_d = 1'b1;
                        state_d = REPORT;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            REPORT: begin
                if (key_ack && valid_q) begin
                    valid_d = 1'b0;
                    cnt_d   = 16'd0;
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!rows_idle) begin
                    cnt_d = 16'd0;
                end else if (cnt_q == RELEASE_LAST) begin
                    cnt_d     = 16'd0;
                    col_idx_d = col_idx_q + 2'd1;
                    col_n_d   = ~(4'b0001 << col_idx_d);
                    state_d   = SCAN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SCAN;
            col_idx_q <= 2'd0;
            col_n_q   <= 4'b1110;
            cnt_q     <= 16'd0;
            valid_q   <= 1'b0;
            code_q    <= 4'h0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            col_n_q   <= col_n_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
        end
    end

    assign col_n     = col_n_q;
    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign scan_col  = col_idx_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix drives row_n from col_n,
// a dwell/streak model predicts every output, plus hand-computed literal checks.
module tb_keypad_scan_ctrl;

    localparam int SETTLE  = 4;
    localparam int RELEASE = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ack;
    logic [1:0] scan_col;

    logic [15:0] keys;

    int vectors = 0;
    int miscompares = 0;

    keypad_scan_ctrl #(
        .SETTLE_CYC (SETTLE),
        .RELEASE_CYC(RELEASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ack  (key_ack),
        .scan_col (scan_col)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    // Model: phase 0 scanning, 1 reporting, 2 awaiting release.
    int         m_phase;
    int         m_col;
    int         m_dwell;
    int         m_streak;
    logic       m_valid;
    logic [3:0] m_code;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_col = 0; m_dwell = 0; m_streak = 0;
            m_valid = 1'b0; m_code = 4'h0;
        end else begin
            case (m_phase)
                0: begin
                    m_dwell++;
                    if (m_dwell == SETTLE) begin
                        m_dwell = 0;
                        if (row_n == 4'b1111) begin
                            m_col = (m_col + 1) % 4;
                        end else begin
                            int r;
                            r = 3;
                            while (r > 0 && row_n[r-1] == 1'b0 ||
                                   r > 0 && row_n[r] == 1'b1) r--;
                            for (int k = 3; k >= 0; k--)
                                if (!row_n[k]) r = k;
                            m_code = 4'(r * 4 + m_col);
                            m_valid = 1'b1;
                            m_phase = 1;
                        end
                    end
                end
                1: begin
                    if (key_ack && m_valid) begin
                        m_valid = 1'b0;
                        m_streak = 0;
                        m_phase = 2;
                    end
                end
                default: begin
                    if (row_n == 4'b1111) begin
                        m_streak++;
                        if (m_streak == RELEASE) begin
                            m_col = (m_col + 1) % 4;
                            m_dwell = 0;
                            m_phase = 0;
                        end
                    end else begin
                        m_streak = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            logic [3:0] exp_col_n;
            exp_col_n = 4'b1111 & ~(4'b0001 << m_col);
            vectors++;
            if (col_n !== exp_col_n || scan_col !== 2'(m_col) ||
                key_valid !== m_valid || key_code !== m_code) begin
                miscompares++;
                $display("FAIL model t=%0t col_n=%b/%b scan_col=%0d/%0d valid=%b/%b code=%h/%h",
                         $time, col_n, exp_col_n, scan_col, m_col,
                         key_valid, m_valid, key_code, m_code);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!key_valid && n < 200);
        check({name, "_valid_seen"}, int'(key_valid), 1);
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        cyc(1);
        key_ack = 1'b0;
    endtask

    task automatic wait_col_change(input string name, output int n);
        logic [1:0] start;
        start = scan_col;
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (scan_col == start && n < 200);
        check({name, "_col_changed"}, int'(scan_col != start), 1);
    endtask

    initial begin
        int n;
        rst = 1'b0; keys = '0; key_ack = 1'b0;
        cyc(2);
        check("rst_col_n", int'(col_n), 4'b1110);
        check("rst_valid", int'(key_valid), 0);
        check("rst_code", int'(key_code), 0);
        check("rst_scan_col", int'(scan_col), 0);
        rst = 1'b1;

        // Idle sweep: each column held SETTLE cycles, wraps after 4*SETTLE.
        cyc(SETTLE);
        check("idle_col1", int'(col_n), 4'b1101);
        cyc(3 * SETTLE);
        check("idle_wrap", int'(col_n), 4'b1110);
        check("idle_valid", int'(key_valid), 0);

        // Key row2/col1 held from reset.
        rst = 1'b0; keys = 16'h0200;
        cyc(1);
        rst = 1'b1;
        wait_valid("k9", n);
        check("k9_latency", n, 2 * SETTLE);
        check("k9_code", int'(key_code), 9);
        check("k9_col_n", int'(col_n), 4'b1101);
        cyc(2);
        ack_pulse();
        check("k9_valid_fall", int'(key_valid), 0);

        // Release bounce: 5 high, 1 low, then high until release is accepted.
        cyc(3);
        keys = '0;
        cyc(5);
        keys = 16'h0200;
        cyc(1);
        keys = '0;
        wait_col_change("bounce", n);
        check("bounce_len", n, RELEASE);
        check("bounce_col", int'(scan_col), 2);

        // Rows 1 and 3 on column 3: row 1 wins.
        keys = 16'h8080;
        wait_valid("multi", n);
        check("multi_code", int'(key_code), 7);
        check("multi_col_n", int'(col_n), 4'b0111);
        ack_pulse();
        keys = '0;
        wait_col_change("multi_rel", n);
        cyc(4 * SETTLE * 3);

        // Stuck consumer: key released during REPORT.
        keys = 16'h0001;
        wait_valid("stuck", n);
        keys = '0;
        cyc(100);
        check("stuck_valid", int'(key_valid), 1);
        check("stuck_code", int'(key_code), 0);
        ack_pulse();
        wait_col_change("stuck_rel", n);
        check("stuck_rel_len", n, RELEASE);

        // Async reset during REPORT.
        keys = 16'h0020;
        wait_valid("rrep", n);
        #3 rst = 1'b0;
        #1;
        check("rrep_valid", int'(key_valid), 0);
        check("rrep_col_n", int'(col_n), 4'b1110);
        check("rrep_code", int'(key_code), 0);
        keys = '0;
        cyc(1);
        rst = 1'b1;

        // Async reset during WAIT_REL, then scan restarts from column 0.
        keys = 16'h0020;
        wait_valid("rwait", n);
        ack_pulse();
        cyc(2);
        #3 rst = 1'b0;
        #1;
        check("rwait_valid", int'(key_valid), 0);
        check("rwait_col_n", int'(col_n), 4'b1110);
        check("rwait_code", int'(key_code), 0);
        keys = '0;
        cyc(1);
        rst = 1'b1;
        cyc(SETTLE - 1);
        check("restart_col0", int'(col_n), 4'b1110);
        cyc(1);
        check("restart_col1", int'(col_n), 4'b1101);
        cyc(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
